sc_csam_sequencer: RTL and testbench



---
 rtl/sc_csam_sequencer_pkg.sv | 36 +++
 rtl/sc_csam_sequencer_if.sv | 41 ++++
 rtl/sc_csam_sequencer_retstack.sv | 66 ++++++
 rtl/sc_csam_sequencer.sv | 112 +++++++++++
 tb/tb_sc_csam_sequencer.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/sc_csam_sequencer_pkg.sv
// Shared definitions for the control-store address sequencer: COND encodings,
// DECODE bit-field positions, flag bit indices and the decode-address helper.
package csam_pkg;

    localparam int CSAM_AW_DEFAULT        = 11;
    localparam int CSAM_IRW_DEFAULT       = 32;
    localparam int CSAM_RETSTACK_DEPTH_DEF = 4;

    typedef enum logic [2:0] {
        COND_NEXT   = 3'b000,
        COND_N      = 3'b001,
        COND_Z      = 3'b010,
        COND_V      = 3'b011,
        COND_C      = 3'b100,
        COND_IR13   = 3'b101,
        COND_JUMP   = 3'b110,
        COND_DECODE = 3'b111
    } csam_cond_e;

    // Flags are packed {n,z,v,c}
    localparam int FLAG_C = 0;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 3;

    localparam int IR_COND_BIT = 13;
    localparam int DEC_OP_HI   = 31;
    localparam int DEC_OP_LO   = 30;
    localparam int DEC_OP3_HI  = 24;
    localparam int DEC_OP3_LO  = 19;

    function automatic logic [10:0] make_decode_addr(input logic [31:0] ir);
        return {1'b1, ir[DEC_OP_HI:DEC_OP_LO], ir[DEC_OP3_HI:DEC_OP3_LO], 2'b00};
    endfunction

endpackage

// File: rtl/sc_csam_sequencer_if.sv
// Sequencer bus: MIR/IR/flag inputs and the registered address/PSR outputs.
// Stack ports exist only when CSAM_RETSTACK_EN is defined.
interface sc_csam_sequencer_if #(
    parameter int DATAWIDTH_BUS_CSAM = 11,
    parameter int DATAWIDTH_IR       = 32
);
    logic [DATAWIDTH_BUS_CSAM-1:0] SC_CSAM_INC_ADDR;
    logic [DATAWIDTH_BUS_CSAM-1:0] SC_CSAM_JUMP_ADDR;
    logic [2:0]                    SC_CSAM_COND;
    logic [DATAWIDTH_IR-1:0]       SC_CSAM_IR;
    logic [3:0]                    SC_CSAM_FLAGS_NZVC;
    logic                          SC_CSAM_FLAGS_LOAD;
    logic                          SC_CSAM_STALL;
    logic [DATAWIDTH_BUS_CSAM-1:0] CSAM_ADDR_OUTPUT;
    logic [3:0]                    CSAM_PSR_NZVC;
`ifdef CSAM_RETSTACK_EN
    logic                          SC_CSAM_CALL;
    logic                          SC_CSAM_RET;
    logic                          CSAM_STACK_ERR;
`endif

    modport master (
        output SC_CSAM_INC_ADDR, SC_CSAM_JUMP_ADDR, SC_CSAM_COND, SC_CSAM_IR,
        output SC_CSAM_FLAGS_NZVC, SC_CSAM_FLAGS_LOAD, SC_CSAM_STALL,
`ifdef CSAM_RETSTACK_EN
        output SC_CSAM_CALL, SC_CSAM_RET,
        input  CSAM_STACK_ERR,
`endif
        input  CSAM_ADDR_OUTPUT, CSAM_PSR_NZVC
    );

    modport slave (
        input  SC_CSAM_INC_ADDR, SC_CSAM_JUMP_ADDR, SC_CSAM_COND, SC_CSAM_IR,
        input  SC_CSAM_FLAGS_NZVC, SC_CSAM_FLAGS_LOAD, SC_CSAM_STALL,
`ifdef CSAM_RETSTACK_EN
        input  SC_CSAM_CALL, SC_CSAM_RET,
        output CSAM_STACK_ERR,
`endif
        output CSAM_ADDR_OUTPUT, CSAM_PSR_NZVC
    );
endinterface

// File: rtl/sc_csam_sequencer_retstack.sv
// Circular micro-return stack: a full push drops the oldest entry, and a pop
// from empty raises a sticky error.
module sc_csam_retstack #(
    parameter int AW    = 11,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall_s,
    input  logic          push_s,
    input  logic          pop_s,
    input  logic [AW-1:0] push_data_s,
    output logic [AW-1:0] top_data_s,
    output logic          empty_s,
    output logic          stack_err_r
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0] mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] top_idx_s;
    logic [CW-1:0] count_r;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) return {PW{1'b0}};
        else                     return p + PW'(1);
    endfunction

    function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
        if (p == {PW{1'b0}}) return PW'(DEPTH - 1);
        else                 return p - PW'(1);
    endfunction

    // Top-of-stack read port
    always_comb begin
        top_idx_s  = ptr_dec(wr_ptr_r);
        top_data_s = mem_r[top_idx_s];
        empty_s    = (count_r == {CW{1'b0}});
    end

    // Pointer, occupancy, storage and sticky error; pop wins over push
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r    <= {PW{1'b0}};
            count_r     <= {CW{1'b0}};
            stack_err_r <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_r[i] <= {AW{1'b0}};
        end else if (stall_s) begin
            wr_ptr_r <= wr_ptr_r;
        end else if (pop_s) begin
            if (empty_s) begin
                stack_err_r <= 1'b1;
            end else begin
                wr_ptr_r <= top_idx_s;
                count_r  <= count_r - CW'(1);
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= push_data_s;
            wr_ptr_r        <= ptr_inc(wr_ptr_r);
            if (count_r != CW'(DEPTH)) count_r <= count_r + CW'(1);
        end else begin
            wr_ptr_r <= wr_ptr_r;
        end
    end
endmodule

// File: rtl/sc_csam_sequencer.sv
// Control-store address sequencer: picks INC/JUMP/DECODE (or stack top) each
// cycle from COND and the latched flags. Optional stack: CSAM_RETSTACK_EN.
module sc_csam_sequencer
    import csam_pkg::*;
#(
    parameter int DATAWIDTH_BUS_CSAM = 11,
    parameter int DATAWIDTH_IR       = 32,
    parameter int RETSTACK_DEPTH     = 4
) (
    input  logic            SC_CSAM_CLOCK_50,
    input  logic            SC_CSAM_RESET_InHigh,
    sc_csam_sequencer_if.slave bus
);
    localparam int AW = DATAWIDTH_BUS_CSAM;

    logic [AW-1:0] addr_r;
    logic [3:0]    psr_r;
    logic [AW-1:0] next_addr_s;
    logic [AW-1:0] decode_addr_s;
    logic          jump_taken_s;
    csam_cond_e    cond_s;

    // Condition evaluation against the latched flags
    always_comb begin
        cond_s        = csam_cond_e'(bus.SC_CSAM_COND);
        decode_addr_s = AW'(make_decode_addr(bus.SC_CSAM_IR[31:0]));
        case (cond_s)
            COND_NEXT:   jump_taken_s = 1'b0;
            COND_N:      jump_taken_s = psr_r[FLAG_N];
            COND_Z:      jump_taken_s = psr_r[FLAG_Z];
            COND_V:      jump_taken_s = psr_r[FLAG_V];
            COND_C:      jump_taken_s = psr_r[FLAG_C];
            COND_IR13:   jump_taken_s = bus.SC_CSAM_IR[IR_COND_BIT];
            COND_JUMP:   jump_taken_s = 1'b1;
            COND_DECODE: jump_taken_s = 1'b0;
            default:     jump_taken_s = 1'b0;
        endcase
    end

`ifdef CSAM_RETSTACK_EN
    logic [AW-1:0] stack_top_s;
    logic          stack_empty_s;
    logic          stack_push_s;
    logic          stack_err_r;

    // CALL only pushes alongside a taken jump, and never when RET is present
    always_comb begin
        stack_push_s = bus.SC_CSAM_CALL & jump_taken_s & ~bus.SC_CSAM_RET;
    end

    sc_csam_retstack #(
        .AW    (AW),
        .DEPTH (RETSTACK_DEPTH)
    ) u_retstack (
        .clk         (SC_CSAM_CLOCK_50),
        .rst         (SC_CSAM_RESET_InHigh),
        .stall_s     (bus.SC_CSAM_STALL),
        .push_s      (stack_push_s),
        .pop_s       (bus.SC_CSAM_RET),
        .push_data_s (bus.SC_CSAM_INC_ADDR),
        .top_data_s  (stack_top_s),
        .empty_s     (stack_empty_s),
        .stack_err_r (stack_err_r)
    );

    assign bus.CSAM_STACK_ERR = stack_err_r;

    // Next-address mux; RET overrides COND and an empty pop yields 0
    always_comb begin
        next_addr_s = bus.SC_CSAM_INC_ADDR;
        if (bus.SC_CSAM_RET) begin
            if (stack_empty_s) next_addr_s = {AW{1'b0}};
            else               next_addr_s = stack_top_s;
        end else if (cond_s == COND_DECODE) begin
            next_addr_s = decode_addr_s;
        end else if (jump_taken_s) begin
            next_addr_s = bus.SC_CSAM_JUMP_ADDR;
        end else begin
            next_addr_s = bus.SC_CSAM_INC_ADDR;
        end
    end
`else
    // Next-address mux
    always_comb begin
        next_addr_s = bus.SC_CSAM_INC_ADDR;
        if (cond_s == COND_DECODE) begin
            next_addr_s = decode_addr_s;
        end else if (jump_taken_s) begin
            next_addr_s = bus.SC_CSAM_JUMP_ADDR;
        end else begin
            next_addr_s = bus.SC_CSAM_INC_ADDR;
        end
    end
`endif

    // Address and flag registers; STALL freezes both
    always_ff @(posedge SC_CSAM_CLOCK_50 or posedge SC_CSAM_RESET_InHigh) begin
        if (SC_CSAM_RESET_InHigh) begin
            addr_r <= {AW{1'b0}};
            psr_r  <= 4'b0000;
        end else if (bus.SC_CSAM_STALL) begin
            addr_r <= addr_r;
            psr_r  <= psr_r;
        end else begin
            addr_r <= next_addr_s;
            if (bus.SC_CSAM_FLAGS_LOAD) psr_r <= bus.SC_CSAM_FLAGS_NZVC;
        end
    end

    assign bus.CSAM_ADDR_OUTPUT = addr_r;
    assign bus.CSAM_PSR_NZVC    = psr_r;
endmodule

// File: tb/tb_sc_csam_sequencer.sv
// Table-driven, scoreboarded bench for sc_csam_sequencer; retstack rows
// are exercised when CSAM_RETSTACK_EN is defined.
module tb_sc_csam_sequencer;
    typedef struct {
        logic [2:0]  cond;
        logic [10:0] inc;
        logic [10:0] jmp;
        logic [31:0] ir;
        logic [3:0]  flags;
        logic        load;
        logic        stall;
        logic        call;
        logic        ret;
        logic [10:0] exp_addr;
        logic [3:0]  exp_psr;
        logic        exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;
    vec_t tbl [24];
    vec_t exp_q [$];

    sc_csam_sequencer_if #(.DATAWIDTH_BUS_CSAM(11), .DATAWIDTH_IR(32)) bus ();

    sc_csam_sequencer #(
        .DATAWIDTH_BUS_CSAM (11),
        .DATAWIDTH_IR       (32),
        .RETSTACK_DEPTH     (4)
    ) dut (
        .SC_CSAM_CLOCK_50     (clk),
        .SC_CSAM_RESET_InHigh (rst),
        .bus                  (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [2:0] cond, input logic [10:0] inc,
                                input logic [10:0] jmp, input logic [31:0] ir,
                                input logic [3:0] flags, input logic load, input logic stall,
                                input logic [10:0] ea, input logic [3:0] ep);
        vec_t v;
        v.cond = cond; v.inc = inc; v.jmp = jmp; v.ir = ir; v.flags = flags;
        v.load = load; v.stall = stall; v.call = 1'b0; v.ret = 1'b0;
        v.exp_addr = ea; v.exp_psr = ep; v.exp_err = 1'b0;
        return v;
    endfunction

    function automatic vec_t mk_rs(input logic call, input logic ret, input logic [2:0] cond,
                                   input logic [10:0] inc, input logic [10:0] jmp,
                                   input logic [10:0] ea, input logic ee);
        vec_t v;
        v = mk(cond, inc, jmp, 32'h0, 4'h0, 1'b0, 1'b0, ea, 4'h0);
        v.call = call; v.ret = ret; v.exp_err = ee;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input vec_t v);
        bus.SC_CSAM_COND       = v.cond;
        bus.SC_CSAM_INC_ADDR   = v.inc;
        bus.SC_CSAM_JUMP_ADDR  = v.jmp;
        bus.SC_CSAM_IR         = v.ir;
        bus.SC_CSAM_FLAGS_NZVC = v.flags;
        bus.SC_CSAM_FLAGS_LOAD = v.load;
        bus.SC_CSAM_STALL      = v.stall;
`ifdef CSAM_RETSTACK_EN
        bus.SC_CSAM_CALL       = v.call;
        bus.SC_CSAM_RET        = v.ret;
`endif
    endtask

    task automatic apply(input string tag, input int idx, input vec_t v);
        vec_t e;
        @(negedge clk);
        drive(v);
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check($sformatf("%s_addr[%0d]", tag, idx), 32'(bus.CSAM_ADDR_OUTPUT), 32'(e.exp_addr));
        check($sformatf("%s_psr[%0d]", tag, idx), 32'(bus.CSAM_PSR_NZVC), 32'(e.exp_psr));
`ifdef CSAM_RETSTACK_EN
        check($sformatf("%s_err[%0d]", tag, idx), 32'(bus.CSAM_STACK_ERR), 32'(e.exp_err));
`endif
    endtask

    initial begin
        //            cond    inc     jmp     ir            flags  ld    st    addr    psr
        tbl[0]  = mk(3'b000, 11'h010, 11'h3A0, 32'h0,        4'h0, 1'b0, 1'b0, 11'h010, 4'h0);
        tbl[1]  = mk(3'b110, 11'h011, 11'h3A0, 32'h0,        4'h0, 1'b0, 1'b0, 11'h3A0, 4'h0);
        tbl[2]  = mk(3'b010, 11'h022, 11'h200, 32'h0,        4'h4, 1'b1, 1'b0, 11'h022, 4'h4);
        tbl[3]  = mk(3'b010, 11'h023, 11'h200, 32'h0,        4'h0, 1'b0, 1'b0, 11'h200, 4'h4);
        tbl[4]  = mk(3'b001, 11'h030, 11'h111, 32'h0,        4'h0, 1'b0, 1'b0, 11'h030, 4'h4);
        tbl[5]  = mk(3'b011, 11'h031, 11'h112, 32'h0,        4'hB, 1'b1, 1'b0, 11'h031, 4'hB);
        tbl[6]  = mk(3'b001, 11'h032, 11'h113, 32'h0,        4'h0, 1'b0, 1'b0, 11'h113, 4'hB);
        tbl[7]  = mk(3'b011, 11'h033, 11'h114, 32'h0,        4'h0, 1'b0, 1'b0, 11'h114, 4'hB);
        tbl[8]  = mk(3'b100, 11'h034, 11'h115, 32'h0,        4'h0, 1'b0, 1'b0, 11'h115, 4'hB);
        tbl[9]  = mk(3'b010, 11'h035, 11'h116, 32'h0,        4'h0, 1'b0, 1'b0, 11'h035, 4'hB);
        tbl[10] = mk(3'b101, 11'h036, 11'h117, 32'h00002000, 4'h0, 1'b0, 1'b0, 11'h117, 4'hB);
        tbl[11] = mk(3'b101, 11'h037, 11'h118, 32'hFFFFDFFF, 4'h0, 1'b0, 1'b0, 11'h037, 4'hB);
        tbl[12] = mk(3'b111, 11'h038, 11'h119, 32'h80080000, 4'h0, 1'b0, 1'b0, 11'h604, 4'hB);
        tbl[13] = mk(3'b111, 11'h039, 11'h11A, 32'hC1F80000, 4'h0, 1'b0, 1'b0, 11'h7FC, 4'hB);
        tbl[14] = mk(3'b111, 11'h03A, 11'h11B, 32'h82000000, 4'h0, 1'b0, 1'b0, 11'h600, 4'hB);
        tbl[15] = mk(3'b111, 11'h03B, 11'h11C, 32'h7E07FFFF, 4'h0, 1'b0, 1'b0, 11'h500, 4'hB);
        tbl[16] = mk(3'b110, 11'h03C, 11'h2AA, 32'h0,        4'h0, 1'b1, 1'b1, 11'h500, 4'hB);
        tbl[17] = mk(3'b110, 11'h03C, 11'h2AA, 32'h0,        4'h0, 1'b1, 1'b1, 11'h500, 4'hB);
        tbl[18] = mk(3'b110, 11'h03C, 11'h2AA, 32'h0,        4'h0, 1'b1, 1'b1, 11'h500, 4'hB);
        tbl[19] = mk(3'b110, 11'h03C, 11'h2AA, 32'h0,        4'h0, 1'b1, 1'b0, 11'h2AA, 4'h0);
        tbl[20] = mk(3'b100, 11'h7FF, 11'h001, 32'h0,        4'h0, 1'b0, 1'b0, 11'h7FF, 4'h0);
        tbl[21] = mk(3'b000, 11'h000, 11'h002, 32'h0,        4'h0, 1'b0, 1'b0, 11'h000, 4'h0);
        tbl[22] = mk(3'b110, 11'h003, 11'h7FF, 32'h0,        4'h0, 1'b0, 1'b0, 11'h7FF, 4'h0);
        tbl[23] = mk(3'b000, 11'h155, 11'h004, 32'h0,        4'hF, 1'b1, 1'b0, 11'h155, 4'hF);

        drive(mk(3'b000, 11'h0, 11'h0, 32'h0, 4'h0, 1'b0, 1'b0, 11'h0, 4'h0));
        #7;
        check("reset_addr", 32'(bus.CSAM_ADDR_OUTPUT), 32'h0);
        check("reset_psr",  32'(bus.CSAM_PSR_NZVC),    32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 24; i++) apply("vec", i, tbl[i]);

        // Mid-cycle async reset with ADDR=0x155, PSR=0xF
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_addr", 32'(bus.CSAM_ADDR_OUTPUT), 32'h0);
        check("async_rst_psr",  32'(bus.CSAM_PSR_NZVC),    32'h0);
        @(negedge clk);
        rst = 1'b0;

`ifdef CSAM_RETSTACK_EN
        apply("rs", 0, mk_rs(1'b1, 1'b0, 3'b110, 11'h021, 11'h100, 11'h100, 1'b0));
        apply("rs", 1, mk_rs(1'b0, 1'b1, 3'b000, 11'h050, 11'h000, 11'h021, 1'b0));
        for (int i = 0; i < 5; i++)
            apply("push", i, mk_rs(1'b1, 1'b0, 3'b110, 11'h040 + 11'(i), 11'h300 + 11'(i),
                                   11'h300 + 11'(i), 1'b0));
        for (int i = 0; i < 4; i++)
            apply("pop", i, mk_rs(1'b0, 1'b1, 3'b000, 11'h555, 11'h000, 11'h044 - 11'(i), 1'b0));
        apply("pop", 4, mk_rs(1'b0, 1'b1, 3'b000, 11'h555, 11'h000, 11'h000, 1'b1));
        apply("rs", 2, mk_rs(1'b0, 1'b0, 3'b000, 11'h066, 11'h000, 11'h066, 1'b1));
        apply("rs", 3, mk_rs(1'b1, 1'b0, 3'b110, 11'h099, 11'h140, 11'h140, 1'b1));
        apply("rs", 4, mk_rs(1'b1, 1'b1, 3'b110, 11'h0AA, 11'h150, 11'h099, 1'b1));
        apply("rs", 5, mk_rs(1'b0, 1'b1, 3'b000, 11'h0BB, 11'h000, 11'h000, 1'b1));
`endif

        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain: got %0d leftover expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
